// File: rtl/async_fifo_pkg.sv
// Shared helpers for the style-2 asynchronous FIFO pointer blocks.
// Both the write side and the read side import this package.
package async_fifo_pkg;

    // FIFO depth derived from the address width
    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return (b >> 1) ^ b;
    endfunction

    // Prefix XOR of all higher Gray bits; upper zero bits leave narrow pointers intact
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/wptr_full.sv
// Write pointer, pessimistic full flag, fill level and sticky overflow for
// the write side of the style-2 asynchronous FIFO.
module wptr_full
    import async_fifo_pkg::*;
#(
    parameter int ASIZE        = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic             afull_n,
    input  logic [ASIZE-1:0] wq2_rptr,
    input  logic             wovf_clr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE-1:0] wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             wovf
);

    localparam int           DEPTH   = depth_of(ASIZE);
    localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] THRESH_L = (ASIZE+1)'(AFULL_THRESH);

    logic [ASIZE-1:0] wbin_q, wbin_d;
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic             wfull_local_q, wfull_local_d;
    logic [ASIZE:0]   wlevel_q, wlevel_d;
    logic             walmost_full_q, walmost_full_d;
    logic             wovf_q, wovf_d;
    logic             wfull_s;
    logic [ASIZE-1:0] rbin_s;
    logic             wacc;
    logic [ASIZE-1:0] diff;

    // afull_n is fully asynchronous, so only its synchronized copy feeds wfull
    sync_2ff u_afull_sync (
        .clk_i (wclk),
        .rst_i (wrst),
        .d_i   (~afull_n),
        .q_o   (wfull_s)
    );

    assign rbin_s = ASIZE'(gray2bin(32'(wq2_rptr)));
    assign wfull  = wfull_local_q | wfull_s;
    assign wacc   = winc & ~wfull;

    // Next-state pointer, local full, level and overflow computation
    always_comb begin
        wbin_d         = wbin_q + ASIZE'(wacc);
        wptr_d         = ASIZE'(bin2gray(32'(wbin_d)));
        wfull_local_d  = wfull_local_q;
        if (wacc && (wbin_d == rbin_s)) begin
            wfull_local_d = 1'b1;
        end else if (wfull_local_q && (wbin_q != rbin_s)) begin
            wfull_local_d = 1'b0;
        end
        diff           = wbin_d - rbin_s;
        wlevel_d       = wfull_local_d ? DEPTH_L : {1'b0, diff};
        walmost_full_d = (wlevel_d >= THRESH_L);
        wovf_d         = wovf_q;
        if (winc && wfull) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_local_q  <= 1'b0;
            wlevel_q       <= '0;
            walmost_full_q <= 1'b0;
            wovf_q         <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_local_q  <= wfull_local_d;
            wlevel_q       <= wlevel_d;
            walmost_full_q <= walmost_full_d;
            wovf_q         <= wovf_d;
        end
    end

    assign waddr        = wbin_q;
    assign wptr         = wptr_q;
    assign wlevel       = wlevel_q;
    assign walmost_full = walmost_full_q;
    assign wovf         = wovf_q;

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-side pointer and full-flag block of the style-2 asynchronous FIFO. It is the counterpart of the read-pointer/empty block.
- Owns the binary write address and the Gray write pointer. The Gray pointer goes to the asynchronous direction/compare logic.
- Produces a pessimistic full flag from two sources:
  - the async comparator's afull_n, synchronized into wclk;
  - a local compare against the read pointer already synchronized into wclk.
- Also provides a fill level, an almost-full flag and sticky overflow detection for the writer.

Parameters:
- ASIZE, 4, address width; FIFO depth DEPTH = 2**ASIZE.
- AFULL_THRESH, 12, walmost_full asserts when wlevel >= AFULL_THRESH; legal range 1..DEPTH.

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  synchronous active-high reset.
- winc  input  1  write request; accepted only when wfull=0.
- afull_n  input  1  asynchronous active-low "possibly full" from the pointer comparator; treated as fully asynchronous.
- wq2_rptr  input  ASIZE  Gray read pointer, already two-flop synchronized into wclk.
- wovf_clr  input  1  clears wovf.
- waddr  output  ASIZE  binary write address for the RAM.
- wptr  output  ASIZE  registered Gray write pointer.
- wfull  output  1  full flag; writes are blocked while high.
- walmost_full  output  1  registered, wlevel >= AFULL_THRESH.
- wlevel  output  ASIZE+1  registered conservative fill level, range 0..DEPTH.
- wovf  output  1  sticky, set by a write attempted while full.

Behaviour:
- One clock, wclk. Reset is synchronous and active-high on wrst. There is no other reset and no async set.
- Reset, applied at the wclk edge with wrst=1: wbin=0, wptr=0, wfull_local=0, both afull sync stages=0, wlevel=0, walmost_full=0, wovf=0.
  - wrst overrides every other input in that cycle.
  - Reset mid-operation discards the pointer state; the read side must be reset concurrently.
- Write accept: wacc = winc & ~wfull.
  - wbinnext = wbin + wacc, modulo DEPTH; it wraps from DEPTH-1 to 0.
  - wgraynext = (wbinnext>>1) ^ wbinnext.
  - wbin and wptr load wbinnext and wgraynext each edge.
  - waddr = wbin, so the RAM write uses the pre-increment address.
  - Latency: wptr changes the edge after the accepted write.
- Read-pointer decode: rbin_s = Gray-to-binary of wq2_rptr, purely combinational.
- Local full, register wfull_local, evaluated at each edge in this priority:
  1. If wacc and wbinnext == rbin_s: set to 1.
  2. Else if wfull_local=1 and wbin != rbin_s (the reader has advanced): clear to 0.
  3. Else: hold.
- Async-full synchronizer: {wfull_s, wfull_s2} <= {wfull_s2, ~afull_n} every edge, giving 2 cycles of latency.
- wfull = wfull_local | wfull_s. It is combinational OR of registers, so it is glitch-free.
  - Both sources are pessimistic: the lagging read pointer over-states occupancy, so a write is never accepted into a truly full FIFO.
- Level: next-state value, registered.
  - If next wfull_local=1: wlevel = DEPTH.
  - Otherwise: wlevel = (wbinnext - rbin_s) mod DEPTH, zero-extended to ASIZE+1 bits.
  - walmost_full = (next wlevel >= AFULL_THRESH), registered alongside.
- Overflow handling:
  - winc=1 while wfull=1: the write is dropped, with no pointer change, and wovf is set at that edge.
  - wovf clears on wovf_clr=1.
  - If set and clear occur in the same cycle, set wins.
- Boundary cases:
  - Wrap: a write at wbin=DEPTH-1 produces wbin=0 and wptr=0.
  - Simultaneous write and read-pointer advance: rule 1 is evaluated against the current rbin_s, and the conservative level results.
  - winc held high across the full assertion: exactly DEPTH writes are accepted from empty, and the next attempt sets wovf.

Decomposition:
- Shared package async_fifo_pkg holds:
  - the constant function gray2bin(ASIZE);
  - the function bin2gray;
  - the localparam derivation DEPTH = 1<<ASIZE, reused by the read side.
- One natural sub-module: sync_2ff, a 1-bit two-flop synchronizer with synchronous active-high reset, used for afull_n.
- Pointer, full and level logic stay in wptr_full.

Test Plan:
- Reset: drive wrst=1 for 2 cycles with winc=1 and afull_n=0 → after release wbin=0, wptr=0, wlevel=0, wfull=0, wovf=0. afull_n=0 then raises wfull 2 edges later.
- Fill from empty: ASIZE=4, wq2_rptr=0, winc=1 for 16 cycles → waddr sequence 0..15, wptr Gray sequence 0,1,3,2,6,... After the 16th accepted write: wfull=1 and wlevel=16. walmost_full rose when wlevel reached 12.
- Overflow: from full, winc=1 for 1 cycle → wbin is unchanged and wovf=1. Then wovf_clr=1 together with another blocked winc → wovf stays 1. wovf_clr alone → wovf=0.
- Drain release: full with rbin_s=0, then wq2_rptr set to Gray(3) → at the next edge wfull_local=0 and wlevel=13, so wfull=0 provided afull_n=1.
- Wrap: start with wbin=15 and rbin_s=10, then one write → wbin=0, wptr=0, wlevel=6, wfull=0.
- Async full path: afull_n pulsed low for 1 cycle while wfull_local=0 → wfull high for exactly 1 cycle after a 2-edge delay; a winc during that cycle is dropped and sets wovf.
